// File: rtl/sw_max_tracker.sv
// sw_max_tracker
//
// Streaming maximum-score tracker for the Smith-Waterman back end. Each beat
// carries up to LANES cell scores. A registered comparison tree picks the best
// valid lane (stage A). That winner is then folded into a running maximum
// together with its (row, col) position (stage B).
//
// Ports
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   i_start       start a new job (aborts any job in progress)
//   i_valid       beat valid
//   i_last        final beat of the job, qualified by i_valid
//   i_lane_valid  per-lane valid; invalid lanes never win
//   i_score       lane k score at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_row         row index of the beat
//   i_col_base    column of lane 0; lane k sits at i_col_base + k (wrapping)
//   o_max         running maximum score
//   o_row, o_col  position of o_max
//   o_found       a score > 0 has been recorded in this job
//   o_busy        job active or pipeline draining
//   o_done        one-cycle pulse, results final
//
// NUM_FMT = 0: two's complement scores. NUM_FMT = 1: sign-magnitude scores.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no job; beats ignored, outputs hold the last job's result
// RUN    | job active, every valid beat accepted
// DRAIN  | last beat accepted, two cycles while the pipeline empties

module sw_max_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int POS_WIDTH  = 16,
    parameter int NUM_FMT    = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_valid,
    input  logic                        i_last,
    input  logic [LANES-1:0]            i_lane_valid,
    input  logic [LANES*DATA_WIDTH-1:0] i_score,
    input  logic [POS_WIDTH-1:0]        i_row,
    input  logic [POS_WIDTH-1:0]        i_col_base,
    output logic [DATA_WIDTH-1:0]       o_max,
    output logic [POS_WIDTH-1:0]        o_row,
    output logic [POS_WIDTH-1:0]        o_col,
    output logic                        o_found,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int LEAVES = 1 << $clog2(LANES);
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Strict "a is greater than b" in the configured number format.
    function automatic logic score_gt(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
        logic                  res;
        logic                  a_neg;
        logic                  b_neg;
        logic [DATA_WIDTH-2:0] a_mag;
        logic [DATA_WIDTH-2:0] b_mag;
        a_mag = a[DATA_WIDTH-2:0];
        b_mag = b[DATA_WIDTH-2:0];
        // -0 is treated as non-negative so it compares equal to +0
        a_neg = a[DATA_WIDTH-1] && (a_mag != '0);
        b_neg = b[DATA_WIDTH-1] && (b_mag != '0);
        if (NUM_FMT == 0) begin
            res = $signed(a) > $signed(b);
        end else if (!a_neg && b_neg) begin
            res = 1'b1;
        end else if (a_neg && !b_neg) begin
            res = 1'b0;
        end else if (!a_neg) begin
            res = a_mag > b_mag;
        end else begin
            res = a_mag < b_mag;
        end
        return res;
    endfunction

    state_t state_q, state_d;
    logic   drain_cnt_q, drain_cnt_d;

    logic   accept;

    // Comparison tree (combinational, feeds stage A register)
    logic [LEAVES-1:0]            lv_pad;
    logic [LEAVES*DATA_WIDTH-1:0] sc_pad;
    logic                         win_v;
    logic [DATA_WIDTH-1:0]        win_s;
    logic [IDX_W-1:0]             win_i;

    // Stage A
    logic                  a_valid_q;
    logic                  a_last_q;
    logic                  a_cand_q;
    logic [DATA_WIDTH-1:0] a_score_q;
    logic [POS_WIDTH-1:0]  a_row_q;
    logic [POS_WIDTH-1:0]  a_col_q;

    // Stage B / running result
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [POS_WIDTH-1:0]  row_q, row_d;
    logic [POS_WIDTH-1:0]  col_q, col_d;
    logic                  found_q, found_d;
    logic                  done_q, done_d;

    // A beat presented together with i_start already belongs to the new job.
    assign accept = i_valid && (i_start || (state_q == ST_RUN));

    always_comb begin
        lv_pad                            = '0;
        lv_pad[LANES-1:0]                 = i_lane_valid;
        sc_pad                            = '0;
        sc_pad[LANES*DATA_WIDTH-1:0]      = i_score;
    end

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves at
    // LEAVES..2*LEAVES-1. The left child always holds the lower lanes, so
    // taking the right child only when strictly greater gives the
    // lower-lane-wins tie-break.
    always_comb begin
        logic                  node_v [2*LEAVES];
        logic [DATA_WIDTH-1:0] node_s [2*LEAVES];
        logic [IDX_W-1:0]      node_i [2*LEAVES];
        for (int n = 0; n < 2*LEAVES; n++) begin
            node_v[n] = 1'b0;
            node_s[n] = '0;
            node_i[n] = '0;
        end
        for (int k = 0; k < LEAVES; k++) begin
            node_v[LEAVES+k] = lv_pad[k];
            node_s[LEAVES+k] = sc_pad[k*DATA_WIDTH +: DATA_WIDTH];
            node_i[LEAVES+k] = IDX_W'(k);
        end
        for (int n = LEAVES-1; n >= 1; n--) begin
            if (node_v[2*n+1] &&
                (!node_v[2*n] || score_gt(node_s[2*n+1], node_s[2*n]))) begin
                node_s[n] = node_s[2*n+1];
                node_i[n] = node_i[2*n+1];
            end else begin
                node_s[n] = node_s[2*n];
                node_i[n] = node_i[2*n];
            end
            node_v[n] = node_v[2*n] | node_v[2*n+1];
        end
        win_v = node_v[1];
        win_s = node_s[1];
        win_i = node_i[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_cand_q  <= 1'b0;
            a_score_q <= '0;
            a_row_q   <= '0;
            a_col_q   <= '0;
        end else begin
            a_valid_q <= accept;
            a_last_q  <= accept && i_last;
            a_cand_q  <= accept && win_v;
            a_score_q <= win_s;
            a_row_q   <= i_row;
            a_col_q   <= i_col_base + POS_WIDTH'(win_i);
        end
    end

    // Running max starts at 0 and only moves on strictly greater candidates,
    // so non-positive scores are never recorded and earlier beats win ties.
    always_comb begin
        max_d   = max_q;
        row_d   = row_q;
        col_d   = col_q;
        found_d = found_q;
        done_d  = 1'b0;
        if (i_start) begin
            max_d   = '0;
            row_d   = '0;
            col_d   = '0;
            found_d = 1'b0;
        end else if (a_valid_q) begin
            if (a_cand_q && score_gt(a_score_q, max_q)) begin
                max_d   = a_score_q;
                row_d   = a_row_q;
                col_d   = a_col_q;
                found_d = 1'b1;
            end
            done_d = a_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            max_q   <= max_d;
            row_q   <= row_d;
            col_q   <= col_d;
            found_q <= found_d;
            done_q  <= done_d;
        end
    end

    // DRAIN lasts two cycles: down-counter loaded with 1, exit at zero.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (i_start) begin
            if (i_valid && i_last) begin
                state_d     = ST_DRAIN;
                drain_cnt_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_valid && i_last) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 1'b0) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_cnt_d = 1'b0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign o_max   = max_q;
    assign o_row   = row_q;
    assign o_col   = col_q;
    assign o_found = found_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;

endmodule

// File: tb/tb_sw_max_tracker.sv
module tb_sw_max_tracker;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int PW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             valid = 1'b0;
    logic             last = 1'b0;
    logic [LN-1:0]    lane_valid = '0;
    logic [LN*DW-1:0] score = '0;
    logic [PW-1:0]    row = '0;
    logic [PW-1:0]    col_base = '0;

    logic [DW-1:0] tc_max, sm_max;
    logic [PW-1:0] tc_row, sm_row, tc_col, sm_col;
    logic          tc_found, sm_found, tc_busy, sm_busy, tc_done, sm_done;

    sw_max_tracker #(.DATA_WIDTH(DW), .LANES(LN), .POS_WIDTH(PW), .NUM_FMT(0)) dut_tc (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_valid(valid), .i_last(last),
        .i_lane_valid(lane_valid), .i_score(score), .i_row(row), .i_col_base(col_base),
        .o_max(tc_max), .o_row(tc_row), .o_col(tc_col), .o_found(tc_found),
        .o_busy(tc_busy), .o_done(tc_done)
    );

    sw_max_tracker #(.DATA_WIDTH(DW), .LANES(LN), .POS_WIDTH(PW), .NUM_FMT(1)) dut_sm (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_valid(valid), .i_last(last),
        .i_lane_valid(lane_valid), .i_score(score), .i_row(row), .i_col_base(col_base),
        .o_max(sm_max), .o_row(sm_row), .o_col(sm_col), .o_found(sm_found),
        .o_busy(sm_busy), .o_done(sm_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] max_tc;
        logic [PW-1:0] row_tc;
        logic [PW-1:0] col_tc;
        logic          found_tc;
        logic [DW-1:0] max_sm;
        logic [PW-1:0] row_sm;
        logic [PW-1:0] col_sm;
        logic          found_sm;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: index 0 = two's complement, index 1 = sign-magnitude
    bit            m_run = 1'b0;
    int            m_val   [2];
    logic [DW-1:0] m_max   [2];
    logic [PW-1:0] m_row   [2];
    logic [PW-1:0] m_col   [2];
    logic          m_found [2];

    function automatic int fmt_val(input int f, input logic [DW-1:0] s);
        int v;
        if (f == 0) v = int'($signed(s));
        else if (s[DW-1]) v = -int'(s[DW-2:0]);
        else v = int'(s[DW-2:0]);
        return v;
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    task automatic model_clear();
        for (int f = 0; f < 2; f++) begin
            m_val[f]   = 0;
            m_max[f]   = '0;
            m_row[f]   = '0;
            m_col[f]   = '0;
            m_found[f] = 1'b0;
        end
    endtask

    task automatic model_fold(input logic [3:0] lv, input logic [63:0] sc,
                              input logic [15:0] r, input logic [15:0] cb);
        logic [DW-1:0] s;
        int            v;
        for (int k = 0; k < LN; k++) begin
            if (lv[k]) begin
                s = sc[k*DW +: DW];
                for (int f = 0; f < 2; f++) begin
                    v = fmt_val(f, s);
                    if (v > m_val[f]) begin
                        m_val[f]   = v;
                        m_max[f]   = s;
                        m_row[f]   = r;
                        m_col[f]   = cb + 16'(k);
                        m_found[f] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic l, input logic [3:0] lv,
                         input logic [63:0] sc, input logic [15:0] r, input logic [15:0] cb);
        exp_t e;
        @(posedge clk);
        #1;
        start = st; valid = v; last = l; lane_valid = lv; score = sc; row = r; col_base = cb;
        if (st) begin
            model_clear();
            m_run = 1'b1;
        end
        if (v && m_run) begin
            model_fold(lv, sc, r, cb);
            if (l) begin
                e.max_tc = m_max[0]; e.row_tc = m_row[0]; e.col_tc = m_col[0]; e.found_tc = m_found[0];
                e.max_sm = m_max[1]; e.row_sm = m_row[1]; e.col_sm = m_col[1]; e.found_sm = m_found[1];
                e.cyc = cyc + 2;
                sb_q.push_back(e);
                m_run = 1'b0;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
    endtask

    task automatic beat(input logic l, input logic [3:0] lv, input logic [63:0] sc,
                        input logic [15:0] r, input logic [15:0] cb);
        drive(1'b0, 1'b1, l, lv, sc, r, cb);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        check({tag, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tc_max"}, tc_max, 0);
        check({tag, "_tc_row"}, tc_row, 0);
        check({tag, "_tc_col"}, tc_col, 0);
        check({tag, "_tc_found"}, tc_found, 0);
        check({tag, "_tc_busy"}, tc_busy, 0);
        check({tag, "_tc_done"}, tc_done, 0);
        check({tag, "_sm_max"}, sm_max, 0);
        check({tag, "_sm_found"}, sm_found, 0);
        check({tag, "_sm_busy"}, sm_busy, 0);
    endtask

    // Scoreboard side: every o_done must match the oldest expected job result
    always @(negedge clk) begin
        if (rst_n && (tc_done || sm_done)) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_tc", tc_done, 1);
                check("done_sm", sm_done, 1);
                check("tc_max", tc_max, mon_e.max_tc);
                check("tc_row", tc_row, mon_e.row_tc);
                check("tc_col", tc_col, mon_e.col_tc);
                check("tc_found", tc_found, mon_e.found_tc);
                check("sm_max", sm_max, mon_e.max_sm);
                check("sm_row", sm_row, mon_e.row_sm);
                check("sm_col", sm_col, mon_e.col_sm);
                check("sm_found", sm_found, mon_e.found_sm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Basic job, latency and busy timing
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        @(negedge clk);
        check("busy_at_start", tc_busy, 0);
        beat(1'b0, 4'b1111, pack4(16'd5, 16'd9, 16'd9, 16'd2), 16'd0, 16'd0);
        @(negedge clk);
        check("busy_run", tc_busy, 1);
        beat(1'b1, 4'b1111, pack4(16'd9, 16'd3, 16'd1, 16'd0), 16'd1, 16'd4);
        @(negedge clk);
        check("lat_before", tc_max, 0);
        idle();
        @(negedge clk);
        check("lat_after", tc_max, 9);
        idle();
        @(negedge clk);
        check("busy_done_cycle", tc_busy, 1);
        idle();
        @(negedge clk);
        check("busy_after", tc_busy, 0);
        check("done_after", tc_done, 0);
        wait_drain("basic");

        // All scores negative or zero
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b0, 4'b1111, pack4(16'hFFFF, 16'h0000, 16'h8000, 16'h8005), 16'd2, 16'd8);
        beat(1'b0, 4'b1111, pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'd3, 16'd8);
        beat(1'b1, 4'b1111, pack4(16'h9000, 16'hFFFE, 16'h0000, 16'h8001), 16'd4, 16'd8);
        idle();
        wait_drain("nonpos");

        // Sign-magnitude ordering; start, beat and last in one cycle
        drive(1'b1, 1'b1, 1'b1, 4'b1111, pack4(16'h8003, 16'h0002, 16'h8000, 16'h0001), 16'd7, 16'h0010);
        idle();
        wait_drain("sm_mix");
        drive(1'b1, 1'b1, 1'b1, 4'b1111, pack4(16'h8005, 16'h8001, 16'h0000, 16'h0000), 16'd1, 16'd0);
        idle();
        wait_drain("sm_neg");

        // Lane masking and an empty last beat
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b0, 4'b0101, pack4(16'd1, 16'd100, 16'd2, 16'd100), 16'd9, 16'h0020);
        beat(1'b1, 4'b0000, pack4(16'd500, 16'd500, 16'd500, 16'd500), 16'd10, 16'h0030);
        idle();
        wait_drain("mask");

        // Ties within and across beats, column wrap
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b0, 4'b1111, pack4(16'd3, 16'd1, 16'd8, 16'd8), 16'd5, 16'hFFFE);
        beat(1'b1, 4'b1111, pack4(16'd8, 16'd0, 16'd0, 16'd0), 16'd6, 16'd0);
        idle();
        wait_drain("tie_wrap");

        // Back-to-back: new start in the o_done cycle
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b1, 4'b0001, pack4(16'd12, 16'd0, 16'd0, 16'd0), 16'd1, 16'd3);
        idle();
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b1, 4'b0010, pack4(16'd0, 16'd4, 16'd0, 16'd0), 16'd2, 16'd6);
        @(negedge clk);
        check("b2b_cleared_max", tc_max, 0);
        check("b2b_cleared_found", tc_found, 0);
        check("b2b_busy", tc_busy, 1);
        idle();
        wait_drain("b2b");

        // Abort mid-job; new job's beat arrives with the start
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b0, 4'b0001, pack4(16'd50, 16'd0, 16'd0, 16'd0), 16'd1, 16'd0);
        beat(1'b0, 4'b0001, pack4(16'd3, 16'd0, 16'd0, 16'd0), 16'd2, 16'd0);
        drive(1'b1, 1'b1, 1'b1, 4'b0001, pack4(16'd7, 16'd0, 16'd0, 16'd0), 16'd3, 16'd0);
        idle();
        wait_drain("abort");
        check("abort_max", tc_max, 7);

        // Asynchronous reset between beats
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 16'd0, 16'd0);
        beat(1'b0, 4'b0001, pack4(16'd20, 16'd0, 16'd0, 16'd0), 16'd3, 16'd5);
        idle();
        idle();
        @(negedge clk);
        check("pre_reset_max", tc_max, 20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        m_run = 1'b0;
        sb_q.delete();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 4'b1111, pack4(16'd9, 16'd9, 16'd9, 16'd9), 16'd1, 16'd1);
        idle();
        idle();
        idle();
        @(negedge clk);
        check_zero("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sw_max_tracker.md
# sw_max_tracker

Streaming maximum-score tracker for the Smith-Waterman back end. Each cycle it accepts up to LANES cell scores from the PE array (one anti-diagonal slice or row segment), reduces them in a registered comparison tree, and folds the winner into a running maximum with its (row, col) position. It replaces ad-hoc combinational max chains with a parametrised, pipelined unit supporting two number formats and an explicit job start/done protocol.

## Interface
- DATA_WIDTH, 16, score width (matches V/E/F width)
- LANES, 4, scores per beat; any value ≥1
- POS_WIDTH, 16, row/column index width
- NUM_FMT, 0, 0 = two's complement, 1 = sign-magnitude (MSB sign, lower bits magnitude)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start new job: clears running max (one-cycle pulse)
- i_valid  in  1  beat valid
- i_last  in  1  final beat of job (qualified by i_valid)
- i_lane_valid  in  LANES  per-lane valid; invalid lanes never win
- i_score  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_row  in  POS_WIDTH  row index of the beat
- i_col_base  in  POS_WIDTH  column of lane 0; lane k column = i_col_base + k (mod 2^POS_WIDTH)
- o_max  out  DATA_WIDTH  running maximum score
- o_row, o_col  out  POS_WIDTH each  position of o_max
- o_found  out  1  some score > 0 has been recorded this job
- o_busy  out  1  job active or pipeline draining
- o_done  out  1  one-cycle pulse: results final

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: i_valid ignored. i_start → RUN, clears o_max=0, o_row=o_col=0, o_found=0, flushes pipeline.
- RUN: each i_valid beat accepted (no backpressure). i_valid & i_last → DRAIN.
- DRAIN: 2 cycles, then o_done pulse and → IDLE. Outputs hold until next i_start.
- i_start in any state aborts the current job (in-flight beats discarded, no o_done) and restarts; an i_valid beat in the same cycle as i_start belongs to the new job, and i_last in that cycle is honoured.
- Stage A (registered): binary comparison tree over valid lanes, producing winner score, lane index, row, column, and a "beat has a candidate" flag. Beat with no valid lane carries no candidate but i_last still propagates.
- Stage B: candidate replaces running max only if strictly greater; then o_found=1.
- Running max starts at 0, so scores ≤ 0 are never recorded (local-alignment floor).
- Tie-break: within a beat the lower lane index wins; across beats the earlier beat wins (strict >).
- Comparison: NUM_FMT=0 signed two's complement. NUM_FMT=1 sign-magnitude: positive > negative; both positive: larger magnitude wins; both negative: smaller magnitude wins; +0 and −0 equal.
- No arithmetic on scores; column add wraps modulo 2^POS_WIDTH.

## Timing
- Reset values: o_max=0, o_row=0, o_col=0, o_found=0, o_busy=0, o_done=0, state IDLE, pipeline valids 0.
- Beat accepted in cycle t: registered into stage A at edge ending t, folded into outputs at edge ending t+1; visible on o_max/o_row/o_col in cycle t+2.
- i_last accepted in cycle t → o_done high in cycle t+2 with final outputs; o_busy high from the cycle after i_start through cycle t+2, low in t+3.
- Back-to-back jobs: i_start may be asserted in the same cycle as o_done; o_done still fires for the finished job, and outputs clear the next cycle.
- rst_n low mid-job: all state clears immediately, no o_done.

## Test plan
- DATA_WIDTH=16, LANES=4, NUM_FMT=0: start; beats row 0 col_base 0 scores {5,9,9,2}, row 1 col_base 4 {9,3,1,0} last → o_max=9, o_row=0, o_col=1, o_found=1, o_done exactly 2 cycles after last.
- All scores negative or zero over 3 beats → o_max=0, o_found=0, o_row=o_col=0, o_done pulses.
- NUM_FMT=1: lanes {0x8003 (−3), 0x0002, 0x8000 (−0), 0x0001} → winner 0x0002 lane 1; lanes {0x8005, 0x8001, 0,0} alone → o_found=0.
- i_lane_valid=4'b0101 with scores {1,100,2,100} → winner 2 at lane 2; beat with i_lane_valid=0 and i_last → done, outputs unchanged.
- Abort: mid-job i_start with beat score 7 same cycle, prior max 50 → no o_done for old job, new job ends with o_max=7.
- Async reset asserted between two beats → all outputs 0 immediately; i_valid without i_start afterwards ignored.
